fp16_add_sequencer: RTL

//  Multi-cycle FP16 (1/5/10) adder controller that sequences one shared 16-bit integer adder (a, b, cin -> 17-bit sum).

---
 rtl/fp16_pkg.sv | 38 +++
 rtl/fp16_lzc.sv | 15 +
 rtl/fp16_add_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/fp16_pkg.sv
// Shared types and constants for the FP16 add sequencer.
// Field helpers keep the operand classification in one place.
package fp16_pkg;

  localparam int EXP_W = 5;
  localparam int MAN_W = 10;
  localparam int BIAS  = 15;

  localparam logic [15:0] QNAN = 16'h7E00;
  localparam logic [15:0] PINF = 16'h7C00;

  typedef enum logic [2:0] {
    IDLE,
    CMP,
    EXP,
    MAN,
    NORM,
    DONE
  } state_t;

  function automatic logic is_nan(input logic [15:0] x);
    return (&x[14:10]) && (|x[9:0]);
  endfunction

  function automatic logic is_inf(input logic [15:0] x);
    return (&x[14:10]) && !(|x[9:0]);
  endfunction

  // Denormals become signed zero so the hidden bit stays clear.
  function automatic logic [15:0] flush(input logic [15:0] x);
    return (x[14:10] == '0) ? {x[15], 15'b0} : x;
  endfunction

  function automatic logic [MAN_W:0] mant(input logic [15:0] x);
    return {|x[14:10], x[9:0]};
  endfunction

endpackage

// File: rtl/fp16_lzc.sv
// Leading-zero count of an 11-bit mantissa field.
// All-zero input reports 11.
module fp16_lzc (
  input  logic [10:0] value,
  output logic [3:0]  count
);

  always_comb begin
    count = 4'd11;
    for (int i = 0; i < 11; i++) begin
      if (value[i]) count = 4'(10 - i);
    end
  end

endmodule

// File: rtl/fp16_add_sequencer.sv
// FP16 adder controller: four passes through one external
// shared integer adder per operation.
module fp16_add_sequencer
  import fp16_pkg::*;
#(
  parameter int ADD_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [15:0]      op_a,
  input  logic [15:0]      op_b,
  output logic             result_valid,
  input  logic             result_ready,
  output logic [15:0]      result,
  output logic [ADD_W-1:0] add_a,
  output logic [ADD_W-1:0] add_b,
  output logic             add_cin,
  input  logic [ADD_W:0]   add_sum
);

  localparam int MW = MAN_W + 1;

  state_t state;

  logic [15:0]      a_r;
  logic [15:0]      b_r;
  logic             spec_r;
  logic [15:0]      spec_val;
  logic             sign_r;
  logic [EXP_W-1:0] e_big;
  logic [EXP_W-1:0] e_small;
  logic [MW-1:0]    m_big;
  logic [MW-1:0]    m_small;
  logic [MW:0]      sum_r;

  logic             eff_sub;
  logic [3:0]       lzc;
  logic [MW-1:0]    shl;
  logic [MAN_W-1:0] man_n;
  logic signed [ADD_W-1:0] exp_adj;
  logic [15:0]      res_n;
  logic [EXP_W-1:0] diff;

  logic nan_in;
  logic inf_a;
  logic inf_b;

  fp16_lzc u_lzc (
    .value (sum_r[MW-1:0]),
    .count (lzc)
  );

  assign eff_sub = a_r[15] ^ b_r[15];
  assign diff    = add_sum[EXP_W-1:0];

  assign inf_a  = is_inf(op_a);
  assign inf_b  = is_inf(op_b);
  assign nan_in = is_nan(op_a) || is_nan(op_b)
               || (inf_a && inf_b && (op_a[15] != op_b[15]));

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    unique case (state)
      CMP: begin
        add_a   = ADD_W'(a_r[14:0]);
        add_b   = ~ADD_W'(b_r[14:0]);
        add_cin = 1'b1;
      end
      EXP: begin
        add_a   = ADD_W'(e_big);
        add_b   = ~ADD_W'(e_small);
        add_cin = 1'b1;
      end
      MAN: begin
        add_a   = ADD_W'(m_big);
        add_b   = eff_sub ? ~ADD_W'(m_small) : ADD_W'(m_small);
        add_cin = eff_sub;
      end
      NORM: begin
        add_a = ADD_W'(e_big);
        if (sum_r[MW]) begin
          add_b = ADD_W'(1);
        end else begin
          add_b   = ~ADD_W'(lzc);
          add_cin = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Adjusted exponent is signed: left shifts can push it below zero.
  assign exp_adj = $signed(add_sum[ADD_W-1:0]);
  assign shl     = sum_r[MW-1:0] << lzc;
  assign man_n   = sum_r[MW] ? sum_r[MW-1:1] : shl[MAN_W-1:0];

  always_comb begin
    if (spec_r)
      res_n = spec_val;
    else if (sum_r == '0)
      res_n = '0;
    else if (exp_adj <= 0)
      res_n = {sign_r, 15'b0};
    else if (exp_adj >= 31)
      res_n = {sign_r, PINF[14:0]};
    else
      res_n = {sign_r, exp_adj[EXP_W-1:0], man_n};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      start_ready  <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
      a_r          <= '0;
      b_r          <= '0;
      spec_r       <= 1'b0;
      spec_val     <= '0;
      sign_r       <= 1'b0;
      e_big        <= '0;
      e_small      <= '0;
      m_big        <= '0;
      m_small      <= '0;
      sum_r        <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_valid && start_ready) begin
            a_r         <= flush(op_a);
            b_r         <= flush(op_b);
            spec_r      <= nan_in || inf_a || inf_b;
            spec_val    <= nan_in ? QNAN : (inf_a ? op_a : op_b);
            start_ready <= 1'b0;
            state       <= CMP;
          end else begin
            start_ready <= 1'b1;
          end
        end
        CMP: begin
          if (add_sum[ADD_W]) begin
            sign_r  <= a_r[15];
            e_big   <= a_r[14:10];
            m_big   <= mant(a_r);
            e_small <= b_r[14:10];
            m_small <= mant(b_r);
          end else begin
            sign_r  <= b_r[15];
            e_big   <= b_r[14:10];
            m_big   <= mant(b_r);
            e_small <= a_r[14:10];
            m_small <= mant(a_r);
          end
          state <= EXP;
        end
        EXP: begin
          m_small <= (diff >= EXP_W'(12)) ? '0 : (m_small >> diff);
          state   <= MAN;
        end
        MAN: begin
          sum_r <= add_sum[MW:0];
          state <= NORM;
        end
        NORM: begin
          result       <= res_n;
          result_valid <= 1'b1;
          state        <= DONE;
        end
        DONE: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            start_ready  <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
